// File: rtl/keypad_matrix_scan_if.sv
// Pin-side bundle of the matrix keypad scanner: row returns in, column drive and key report out.
interface keypad_matrix_scan_if #(
  parameter int ROWS = 4,
  parameter int COLS = 3
);
  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;

  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_matrix_scan.sv
// ROWS x COLS matrix keypad scanner: column drive, row synchroniser, press/release
// debounce and single-key report with optional auto-repeat.
module keypad_matrix_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 3,
  parameter int SCAN_DIV   = 4,
  parameter int DEB_CYC    = 8,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_CYC = 64
) (
  input logic clk,
  input logic rst,
  keypad_matrix_scan_if.master bus
);

  localparam int KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(REPEAT_CYC + 1);

  localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0] RPT_LAST = PW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [ROWS-1:0] row_m;
  logic [ROWS-1:0] row_s;
  logic [1:0]      state;
  logic [CW-1:0]   col_idx;
  logic [SW-1:0]   div_cnt;
  logic [DW-1:0]   deb_cnt;
  logic [PW-1:0]   rpt_cnt;
  logic [RW-1:0]   row_sel;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;

  logic [RW-1:0]   low_row;
  logic            any_row;
  logic            row_hit;
  logic [CW-1:0]   col_wrap;
  logic [KW-1:0]   code_now;
  logic            rpt_wrap;

  // Lowest-index set row of the synchronised returns.
  always_comb begin
    low_row = '0;
    any_row = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (row_s[i] && !any_row) begin
        low_row = RW'(i);
        any_row = 1'b1;
      end
    end
  end

  always_comb begin
    row_hit  = row_s[row_sel];
    col_wrap = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
    code_now = KW'(32'(row_sel) * COLS + 32'(col_idx));
    rpt_wrap = (rpt_cnt == RPT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_m     <= '0;
      row_s     <= '0;
      state     <= S_SCAN;
      col_idx   <= '0;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      rpt_cnt   <= '0;
      row_sel   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      row_m     <= bus.row_in;
      row_s     <= row_m;
      key_valid <= 1'b0;
      case (state)
        S_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (any_row) begin
              row_sel <= low_row;
              deb_cnt <= DW'(1);
              state   <= S_DEBOUNCE;
            end else begin
              col_idx <= col_wrap;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DEBOUNCE: begin
          if (!row_hit) begin
            deb_cnt <= '0;
            col_idx <= col_wrap;
            state   <= S_SCAN;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt   <= '0;
            rpt_cnt   <= '0;
            key_code  <= code_now;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= S_HELD;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        S_HELD: begin
          if (REPEAT_EN != 0) begin
            rpt_cnt <= rpt_wrap ? '0 : rpt_cnt + 1'b1;
            if (rpt_wrap && row_hit) key_valid <= 1'b1;
          end
          if (!row_hit) begin
            deb_cnt <= DW'(1);
            state   <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Repeat timebase keeps running so a bounce back to HELD does not shift it.
          if (REPEAT_EN != 0) rpt_cnt <= rpt_wrap ? '0 : rpt_cnt + 1'b1;
          if (row_hit) begin
            deb_cnt <= '0;
            state   <= S_HELD;
          end else if (deb_cnt == DEB_LAST) begin
            deb_cnt  <= '0;
            rpt_cnt  <= '0;
            key_held <= 1'b0;
            col_idx  <= col_wrap;
            state    <= S_SCAN;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        default: state <= S_SCAN;
      endcase
    end
  end

  assign bus.col_out   = COLS'(1) << col_idx;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held  = key_held;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan: a non-repeating and an auto-repeating instance share one keypad.
module tb_keypad_matrix_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  keypad_matrix_scan_if #(.ROWS(4), .COLS(3)) bus0 ();
  keypad_matrix_scan_if #(.ROWS(4), .COLS(3)) bus1 ();
  assign bus0.row_in = row_in;
  assign bus1.row_in = row_in;

  keypad_matrix_scan #(
    .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEB_CYC(8), .REPEAT_EN(0), .REPEAT_CYC(64)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  keypad_matrix_scan #(
    .ROWS(4), .COLS(3), .SCAN_DIV(4), .DEB_CYC(8), .REPEAT_EN(1), .REPEAT_CYC(64)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance to the cycle in which col_out first switches to t.
  task automatic wait_col(input logic [2:0] t);
    int n = 0;
    while (bus0.col_out === t && n < 20) begin tick(); n++; end
    while (bus0.col_out !== t && n < 40) begin tick(); n++; end
    check("wait_col", 32'(bus0.col_out), 32'(t));
  endtask

  task automatic observe(input int n, output int nv, output int vt,
                         output logic [31:0] code, output logic held_min);
    nv = 0; vt = -1; code = '1; held_min = 1'b1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus0.key_valid === 1'b1) begin
        nv++;
        if (vt < 0) vt = k;
        code = 32'(bus0.key_code);
      end
      if (bus0.key_held !== 1'b1) held_min = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col0"},   32'(bus0.col_out),   32'd1);
    check({tag, "_valid0"}, 32'(bus0.key_valid), 32'd0);
    check({tag, "_held0"},  32'(bus0.key_held),  32'd0);
    check({tag, "_code0"},  32'(bus0.key_code),  32'd0);
    check({tag, "_col1"},   32'(bus1.col_out),   32'd1);
    check({tag, "_held1"},  32'(bus1.key_held),  32'd0);
  endtask

  initial begin
    int nv, vt, cnt0, cnt1, n;
    int off [4];
    logic [31:0] code;
    logic held_min, found;

    // 1: power-on reset, then asynchronous reset in the middle of a column dwell
    repeat (2) tick();
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (6) tick();
    check("scan_mid", 32'(bus0.col_out), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("step_c0", 32'(bus0.col_out), 32'd1);
    tick();
    check("step_c1", 32'(bus0.col_out), 32'd2);
    repeat (3) tick();
    check("dwell_c1", 32'(bus0.col_out), 32'd2);
    tick();
    check("step_c2", 32'(bus0.col_out), 32'd4);
    repeat (4) tick();
    check("wrap_c0", 32'(bus0.col_out), 32'd1);

    // 2: row 2 in column 1 -> key 7, pulse 11 cycles after the column comes up
    wait_col(3'b010);
    row_in = 4'b0100;
    observe(40, nv, vt, code, held_min);
    check("k7_pulses", 32'(nv), 32'd1);
    check("k7_latency", 32'(vt), 32'd11);
    check("k7_code", code, 32'd7);
    check("k7_held", 32'(bus0.key_held), 32'd1);
    check("k7_col_frozen", 32'(bus0.col_out), 32'd2);
    row_in = 4'b0000;
    repeat (9) tick();
    check("k7_rel_early", 32'(bus0.key_held), 32'd1);
    tick();
    check("k7_rel_held", 32'(bus0.key_held), 32'd0);
    check("k7_rel_col", 32'(bus0.col_out), 32'd4);
    check("k7_code_kept", 32'(bus0.key_code), 32'd7);

    // 3: 3-cycle bounce on row 0 in column 0
    wait_col(3'b001);
    row_in = 4'b0001;
    repeat (3) tick();
    row_in = 4'b0000;
    repeat (2) tick();
    check("bounce_frozen", 32'(bus0.col_out), 32'd1);
    tick();
    check("bounce_resume", 32'(bus0.col_out), 32'd2);
    observe(10, nv, vt, code, held_min);
    check("bounce_pulses", 32'(nv), 32'd0);
    check("bounce_held", 32'(bus0.key_held), 32'd0);

    // 5: rows 1 and 3 in column 2 -> key 5; extra key and release glitch ignored
    wait_col(3'b100);
    row_in = 4'b1010;
    observe(30, nv, vt, code, held_min);
    check("k5_pulses", 32'(nv), 32'd1);
    check("k5_latency", 32'(vt), 32'd11);
    check("k5_code", code, 32'd5);
    row_in = 4'b1011;
    observe(30, nv, vt, code, held_min);
    check("k5_second_pulses", 32'(nv), 32'd0);
    check("k5_second_held", 32'(held_min), 32'd1);
    check("k5_second_code", 32'(bus0.key_code), 32'd5);
    row_in = 4'b0000;
    repeat (4) tick();
    row_in = 4'b1011;
    observe(20, nv, vt, code, held_min);
    check("k5_glitch_pulses", 32'(nv), 32'd0);
    check("k5_glitch_held", 32'(held_min), 32'd1);
    row_in = 4'b0000;
    n = 0;
    while (bus0.key_held === 1'b1 && n < 20) begin tick(); n++; end
    check("k5_rel_held", 32'(bus0.key_held), 32'd0);
    check("k5_rel_col", 32'(bus0.col_out), 32'd1);

    // 4: auto-repeat on the REPEAT_EN=1 instance, row 1 column 1 -> key 4
    wait_col(3'b010);
    row_in = 4'b0010;
    found = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus1.key_valid === 1'b1) begin found = 1'b1; break; end
    end
    check("rpt_first", 32'(found), 32'd1);
    check("rpt_first_code", 32'(bus1.key_code), 32'd4);
    cnt1 = 1;
    cnt0 = (bus0.key_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) off[i] = -1;
    for (int j = 1; j <= 200; j++) begin
      tick();
      if (bus1.key_valid === 1'b1) begin
        if (cnt1 < 4) off[cnt1] = j;
        cnt1++;
        check("rpt_code", 32'(bus1.key_code), 32'd4);
      end
      if (bus0.key_valid === 1'b1) cnt0++;
    end
    check("rpt_count", 32'(cnt1), 32'd4);
    check("rpt_off1", 32'(off[1]), 32'd64);
    check("rpt_off2", 32'(off[2]), 32'd128);
    check("rpt_off3", 32'(off[3]), 32'd192);
    check("norpt_count", 32'(cnt0), 32'd1);
    check("rpt_held", 32'(bus1.key_held), 32'd1);

    // 6: reset while held; key still down afterwards is re-detected in column 0
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_held");
    tick();
    rst = 1'b0;
    observe(30, nv, vt, code, held_min);
    check("redet_pulses", 32'(nv), 32'd1);
    check("redet_latency", 32'(vt), 32'd11);
    check("redet_code", code, 32'd3);
    check("redet_held", 32'(bus0.key_held), 32'd1);
    check("redet_code1", 32'(bus1.key_code), 32'd3);
    row_in = 4'b0000;
    n = 0;
    while (bus0.key_held === 1'b1 && n < 20) begin tick(); n++; end
    check("final_rel", 32'(bus0.key_held), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
